typedef_array_deser: RTL and testbench

//   Serial-to-parallel reader for packed, 1-indexed typedef'd logic arrays.
//   - Storage type: `typedef logic logic_alias;`, vectors declared `logic_alias [WIDTH:1]`.
//   - Accepts one bit per handshake and assembles a WIDTH-bit word.
//   - Presents the word on a valid/ready output port.
//   - Serves as the receiving end for tests that drive such vectors.
//   - Exercises non-zero-based packed typedef arrays in sequential logic.
//

---
 rtl/typedef_array_deser_if.sv | 25 ++
 rtl/typedef_array_deser.sv | 101 ++++++++++
 tb/tb_typedef_array_deser.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/typedef_array_deser_if.sv
// Serial-bit input and assembled-word output of the deserialiser, with word counter.
// master = producer/consumer side, slave = the deserialiser.
interface typedef_array_deser_if #(
  parameter int WIDTH = 6
);
  typedef logic logic_alias;

  logic                   sin_valid;
  logic                   sin_ready;
  logic                   sin_bit;
  logic                   par_valid;
  logic                   par_ready;
  logic_alias [WIDTH:1]   par_data;
  logic [7:0]             word_count;

  modport master (
    output sin_valid, sin_bit, par_ready,
    input  sin_ready, par_valid, par_data, word_count
  );

  modport slave (
    input  sin_valid, sin_bit, par_ready,
    output sin_ready, par_valid, par_data, word_count
  );
endinterface

// File: rtl/typedef_array_deser.sv
// Serial-to-parallel reader: one bit per handshake into a 1-indexed logic_alias [WIDTH:1] word.
// Word valid 1 cycle after last-bit accept; HOLD with par_ready low stalls serial input.
module typedef_array_deser #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  typedef_array_deser_if.slave bus
);
  typedef logic logic_alias;
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic_alias [WIDTH:1] sr_q, sr_d;
  logic_alias [WIDTH:1] data_q, data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           wc_q, wc_d;

  logic                 par_vld;
  logic                 sin_rdy;
  logic                 sin_acc;
  logic                 par_hs;
  logic                 last_bit;
  logic_alias [WIDTH:1] sr_shift;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wc_q    <= wc_d;
    end
  end

  // Output decode: the ready path is combinational so a consumer draining the
  // held word can let the next serial bit in during the same cycle.
  always_comb begin
    par_vld = (state_q == HOLD);
    sin_rdy = !par_vld || bus.par_ready;
  end

  always_comb begin
    sin_acc  = bus.sin_valid && sin_rdy;
    par_hs   = par_vld && bus.par_ready;
    last_bit = sin_acc && (cnt_q == CNT_LAST);
    if (MSB_FIRST) begin
      sr_shift = {sr_q[WIDTH-1:1], bus.sin_bit};
    end else begin
      sr_shift = {bus.sin_bit, sr_q[WIDTH:2]};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (last_bit) state_d = HOLD;
      HOLD:    if (par_hs && !last_bit) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    wc_d   = wc_q;
    if (sin_acc) begin
      sr_d  = sr_shift;
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
    end
    if (last_bit) begin
      data_d = sr_shift;
    end
    if (par_hs) begin
      wc_d = wc_q + 8'd1;
    end
  end

  assign bus.par_valid  = par_vld;
  assign bus.sin_ready  = sin_rdy;
  assign bus.par_data   = data_q;
  assign bus.word_count = wc_q;

  a_cnt_range: assert property (@(posedge clk) disable iff (reset) cnt_q <= CNT_LAST);
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (par_vld && !bus.par_ready) |=> ($stable(data_q) && $stable(wc_q) && $stable(cnt_q)));

endmodule

// File: tb/tb_typedef_array_deser.sv
// Drives an MSB-first and an LSB-first instance with identical serial stimulus and
// checks both against a bit-queue reference model plus fixed vector tables.
module tb_typedef_array_deser;
  localparam int W = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sin_valid = 1'b0;
  logic sin_bit = 1'b0;
  logic par_ready = 1'b0;

  always #5 clk = ~clk;

  typedef_array_deser_if #(.WIDTH(W)) ifm ();
  typedef_array_deser_if #(.WIDTH(W)) ifl ();

  assign ifm.sin_valid = sin_valid;
  assign ifm.sin_bit   = sin_bit;
  assign ifm.par_ready = par_ready;
  assign ifl.sin_valid = sin_valid;
  assign ifl.sin_bit   = sin_bit;
  assign ifl.par_ready = par_ready;

  typedef_array_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(ifm.slave));
  typedef_array_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(ifl.slave));

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: collected bits in arrival order, pending word and count.
  bit         mb[$];
  bit         m_vld;
  bit [W-1:0] m_dat_m, m_dat_l;
  bit [7:0]   m_wc;
  bit         chk_en = 1'b0;
  int         cyc = 0;
  int         vld_cycles[$];

  task automatic model_update();
    bit rdy, acc, hs;
    if (reset) begin
      mb.delete();
      m_vld = 1'b0; m_dat_m = '0; m_dat_l = '0; m_wc = '0;
      return;
    end
    rdy = !m_vld || par_ready;
    acc = sin_valid && rdy;
    hs  = m_vld && par_ready;
    if (hs) begin
      m_vld = 1'b0;
      m_wc  = m_wc + 8'd1;
    end
    if (acc) begin
      mb.push_back(sin_bit);
      if (mb.size() == W) begin
        for (int i = 0; i < W; i++) begin
          m_dat_m[W-1-i] = mb[i];
          m_dat_l[i]     = mb[i];
        end
        m_vld = 1'b1;
        mb.delete();
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    if (ifm.par_valid === 1'b1) vld_cycles.push_back(cyc);
    if (chk_en) begin
      chk("mdl_vld_m", {31'd0, ifm.par_valid}, {31'd0, m_vld});
      chk("mdl_vld_l", {31'd0, ifl.par_valid}, {31'd0, m_vld});
      chk("mdl_rdy_m", {31'd0, ifm.sin_ready}, {31'd0, !m_vld || par_ready});
      chk("mdl_wc_m", {24'd0, ifm.word_count}, {24'd0, m_wc});
      chk("mdl_wc_l", {24'd0, ifl.word_count}, {24'd0, m_wc});
      if (m_vld) begin
        chk("mdl_dat_m", {26'd0, ifm.par_data}, {26'd0, m_dat_m});
        chk("mdl_dat_l", {26'd0, ifl.par_data}, {26'd0, m_dat_l});
      end
    end
  endtask

  // Bits go out from w[W-1] down to w[0]; sin_valid is left high.
  task automatic feed_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      sin_valid = 1'b1;
      sin_bit   = w[i];
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; sin_valid = 1'b0; par_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] bits;   // bits[W-1] sent first
    logic [W-1:0] exp_m;
    logic [W-1:0] exp_l;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [W-1:0] held;
    logic [7:0]   wc0;
    logic [W-1:0] words[4];

    tbl[0] = '{6'b100001, 6'b100001, 6'b100001};
    tbl[1] = '{6'b110000, 6'b110000, 6'b000011};
    tbl[2] = '{6'b000001, 6'b000001, 6'b100000};
    tbl[3] = '{6'b101100, 6'b101100, 6'b001101};
    tbl[4] = '{6'b011111, 6'b011111, 6'b111110};

    // Reset state
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_vld", {31'd0, ifm.par_valid}, 32'd0);
    chk("rst_dat", {26'd0, ifm.par_data}, 32'd0);
    chk("rst_wc", {24'd0, ifm.word_count}, 32'd0);
    chk("rst_rdy", {31'd0, ifm.sin_ready}, 32'd1);

    // Table vectors: latency, data for both bit orders, count after consumption
    par_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      for (int i = W - 1; i >= 1; i--) begin
        sin_valid = 1'b1; sin_bit = tbl[t].bits[i];
        step();
      end
      chk("tbl_vld_before_last", {31'd0, ifm.par_valid}, 32'd0);
      sin_bit = tbl[t].bits[0];
      step();
      sin_valid = 1'b0;
      chk("tbl_vld_after_last", {31'd0, ifm.par_valid}, 32'd1);
      chk("tbl_dat_msb", {26'd0, ifm.par_data}, {26'd0, tbl[t].exp_m});
      chk("tbl_dat_lsb", {26'd0, ifl.par_data}, {26'd0, tbl[t].exp_l});
      step();
      chk("tbl_vld_drop", {31'd0, ifm.par_valid}, 32'd0);
      chk("tbl_wc", {24'd0, ifm.word_count}, t + 1);
    end

    // Backpressure: held word blocks serial input for 5 cycles
    par_ready = 1'b0;
    feed_word(6'b110101);
    held = ifm.par_data;
    wc0  = ifm.word_count;
    chk("bp_dat", {26'd0, held}, {26'd0, 6'b110101});
    for (int k = 0; k < 5; k++) begin
      sin_valid = 1'b1; sin_bit = $urandom_range(0, 1);
      #1;
      chk("bp_rdy", {31'd0, ifm.sin_ready}, 32'd0);
      step();
      chk("bp_dat_hold", {26'd0, ifm.par_data}, {26'd0, 6'b110101});
      chk("bp_wc_hold", {24'd0, ifm.word_count}, {24'd0, wc0});
    end
    sin_valid = 1'b0; par_ready = 1'b1;
    step();
    chk("bp_wc_inc", {24'd0, ifm.word_count}, {24'd0, wc0 + 8'd1});
    chk("bp_vld_drop", {31'd0, ifm.par_valid}, 32'd0);

    // Reset mid-word discards partial bits
    for (int k = 0; k < 3; k++) begin
      sin_valid = 1'b1; sin_bit = 1'b1;
      step();
    end
    do_reset();
    par_ready = 1'b1;
    feed_word(6'b100001);
    sin_valid = 1'b0;
    chk("rstmid_dat_m", {26'd0, ifm.par_data}, {26'd0, 6'b100001});
    chk("rstmid_dat_l", {26'd0, ifl.par_data}, {26'd0, 6'b100001});
    step();
    chk("rstmid_wc", {24'd0, ifm.word_count}, 32'd1);

    // Reset while holding a word drops it without counting
    par_ready = 1'b0;
    feed_word(6'b010110);
    sin_valid = 1'b0;
    do_reset();
    chk("rsthold_vld", {31'd0, ifm.par_valid}, 32'd0);
    chk("rsthold_wc", {24'd0, ifm.word_count}, 32'd0);

    // Streaming: 4 words over 24 consecutive accepts
    words[0] = 6'b101010; words[1] = 6'b010101; words[2] = 6'b111000; words[3] = 6'b000111;
    par_ready = 1'b1;
    vld_cycles.delete();
    for (int k = 0; k < 4; k++) feed_word(words[k]);
    sin_valid = 1'b0;
    step();
    chk("strm_words", vld_cycles.size(), 32'd4);
    for (int k = 1; k < vld_cycles.size(); k++)
      chk("strm_spacing", vld_cycles[k] - vld_cycles[k-1], W);
    chk("strm_wc", {24'd0, ifm.word_count}, 32'd4);

    // Randomized traffic checked by the model each cycle
    for (int k = 0; k < 600; k++) begin
      sin_valid = ($urandom_range(0, 3) != 0);
      sin_bit   = $urandom_range(0, 1);
      par_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Word counter wrap
    do_reset();
    par_ready = 1'b1;
    for (int k = 0; k < 255; k++) feed_word(W'($urandom));
    sin_valid = 1'b0;
    step();
    chk("wrap_255", {24'd0, ifm.word_count}, 32'd255);
    feed_word(W'($urandom));
    sin_valid = 1'b0;
    step();
    chk("wrap_0", {24'd0, ifm.word_count}, 32'd0);

    if (pass_cnt == tot_cnt) $display("*-* All Finished *-*");
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
